// File: rtl/lsu_sized_pkg.sv
// Shared encodings and size helpers for the sized load/store unit.
// Pure package: no logic, no latency, no flow control.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'(4'd1 << size);
    endfunction

    // Low address bits that must be zero for an access of this size.
    function automatic logic [2:0] mis_mask(input logic [1:0] size);
        return 3'(size_bytes(size) - 4'd1);
    endfunction

endpackage

// File: rtl/lsu_sized_if.sv
// Pipelined Wishbone master bus between the LSU and memory.
// Signal bundle only; timing and flow control belong to the endpoints.
interface lsu_sized_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0]   wbmadr_o;
    logic [DATA_W-1:0]   wbmdat_o;
    logic [DATA_W/8-1:0] wbmsel_o;
    logic                wbmwe_o;
    logic                wbmstb_o;
    logic                wbmcyc_o;
    logic                wbmack_i;
    logic [DATA_W-1:0]   wbmdat_i;

    modport master (
        output wbmadr_o, wbmdat_o, wbmsel_o, wbmwe_o, wbmstb_o, wbmcyc_o,
        input  wbmack_i, wbmdat_i
    );

    modport slave (
        input  wbmadr_o, wbmdat_o, wbmsel_o, wbmwe_o, wbmstb_o, wbmcyc_o,
        output wbmack_i, wbmdat_i
    );
endinterface

// File: rtl/lsu_sized_lane.sv
// Byte-lane steering: store replication/select generation, load extraction and extension (LSU_SIGNEXT_EN).
// Purely combinational, zero latency; no flow control of its own.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int DWB    = DATA_W / 8,
    localparam int OFF_W  = $clog2(DWB)
) (
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        part,
    input  logic [63:0]       st_dat,
    output logic [DATA_W-1:0] bus_dat,
    output logic [DWB-1:0]    bus_sel,
    input  logic [DATA_W-1:0] ld_bus,
    input  logic [63:0]       acc,
    output logic [63:0]       acc_next,
    output logic [63:0]       ld_result
);
    logic              sub;
    logic [7:0]        lanes;
    logic [2:0]        bmask;
    logic [63:0]       st_shift;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_lane;
    logic [5:0]        msb;
    logic [63:0]       res_mask;
    logic              sext;

    assign sub   = 32'(size_bytes(size)) < 32'(DWB);
    assign bmask = mis_mask(size);
    assign lanes = 8'((9'd1 << size_bytes(size)) - 9'd1);

    always_comb begin
        st_shift = st_dat >> (DATA_W * int'(part));
        bus_dat  = st_shift[DATA_W-1:0];
        bus_sel  = '1;
        if (sub) begin
            // Narrow stores repeat their bytes on every lane; sel picks the live ones.
            for (int i = 0; i < DWB; i++) begin
                bus_dat[8*i +: 8] = st_dat[{3'(i) & bmask, 3'b000} +: 8];
            end
            bus_sel = DWB'(lanes << off);
        end
    end

    assign msb      = 6'({size_bytes(size), 3'b000} - 7'd1);
    assign res_mask = ~64'd0 >> (6'd63 - msb);
    assign ld_shift = ld_bus >> {off, 3'b000};
    assign ld_lane  = ld_shift & res_mask[DATA_W-1:0];
    assign acc_next = (acc << DATA_W) | 64'(ld_lane);

`ifdef LSU_SIGNEXT_EN
    assign sext = sgn & acc_next[msb];
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign sext       = 1'b0;
`endif

    assign ld_result = (acc_next & res_mask) | (sext ? ~res_mask : 64'd0);

endmodule

// File: rtl/lsu_sized.sv
// Sized load/store unit on a pipelined Wishbone master; sign extension enabled by LSU_SIGNEXT_EN.
// Load result NB+1 cycles after request with zero-wait acks; busy_o stalls upstream for the whole access.
module lsu_sized
    import lsu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       dat_i,
    input  logic              we_i,
    input  logic              nomem_i,
    input  logic              req_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    output logic              busy_o,
    output logic              rwe_o,
    output logic [63:0]       dat_o,
    output logic              mis_o,
    lsu_sized_if.master       wb
);
    localparam int DWB   = DATA_W / 8;
    localparam int OFF_W = $clog2(DWB);

    function automatic logic [2:0] beats_of(input logic [1:0] size);
        if (32'(size_bytes(size)) >= 32'(DWB)) begin
            return 3'(32'(size_bytes(size)) / 32'(DWB));
        end
        return 3'd1;
    endfunction

    state_e            state, state_n;
    logic [ADDR_W-1:0] l_addr;
    logic [63:0]       l_dat;
    logic              l_we, l_sgn;
    logic [1:0]        l_size;
    logic [1:0]        part, part_n;
    logic [2:0]        nb, nb_n;
    logic [2:0]        ack_cnt, ack_cnt_n;
    logic [63:0]       acc, acc_n;
    logic              accept;

    logic              busy_n, rwe_n, mis_n;
    logic [63:0]       dat_n;
    logic [ADDR_W-1:0] adr_n;
    logic [DATA_W-1:0] wdat_n;
    logic [DWB-1:0]    sel_n;
    logic              we_n, stb_n, cyc_n;

    logic              idle, misaligned, ack_hit;
    logic [1:0]        src_size;
    logic [63:0]       src_dat;
    logic [ADDR_W-1:0] src_addr;
    logic [1:0]        beat_part;
    logic [ADDR_W-1:0] beat_adr;
    logic [DATA_W-1:0] lane_dat;
    logic [DWB-1:0]    lane_sel;
    logic [63:0]       lane_acc, lane_res;

    assign idle       = (state == ST_IDLE);
    assign misaligned = |(addr_i[2:0] & mis_mask(size_i));
    assign ack_hit    = wb.wbmack_i & ~idle;

    // The first beat is built from live inputs; later beats from the latched copy.
    assign src_size  = idle ? size_i : l_size;
    assign src_dat   = idle ? dat_i  : l_dat;
    assign src_addr  = idle ? addr_i : l_addr;
    assign beat_part = idle ? 2'(beats_of(size_i) - 3'd1) : part - 2'd1;
    assign beat_adr  = src_addr + ADDR_W'(int'(beat_part) * DWB);

    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .size      (src_size),
        .sgn       (l_sgn),
        .off       (src_addr[OFF_W-1:0]),
        .part      (beat_part),
        .st_dat    (src_dat),
        .bus_dat   (lane_dat),
        .bus_sel   (lane_sel),
        .ld_bus    (wb.wbmdat_i),
        .acc       (acc),
        .acc_next  (lane_acc),
        .ld_result (lane_res)
    );

    always_comb begin
        state_n   = state;
        part_n    = part;
        nb_n      = nb;
        ack_cnt_n = ack_cnt;
        acc_n     = acc;
        accept    = 1'b0;
        busy_n    = busy_o;
        rwe_n     = 1'b0;
        mis_n     = 1'b0;
        dat_n     = dat_o;
        adr_n     = wb.wbmadr_o;
        wdat_n    = wb.wbmdat_o;
        sel_n     = wb.wbmsel_o;
        we_n      = wb.wbmwe_o;
        stb_n     = wb.wbmstb_o;
        cyc_n     = wb.wbmcyc_o;

        case (state)
            ST_IDLE: begin
                if (nomem_i) begin
                    dat_n = 64'(addr_i);
                    rwe_n = 1'b1;
                end else if (req_i) begin
                    if (misaligned) begin
                        mis_n = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        nb_n      = beats_of(size_i);
                        part_n    = beat_part;
                        ack_cnt_n = 3'd0;
                        acc_n     = 64'd0;
                        busy_n    = 1'b1;
                        stb_n     = 1'b1;
                        cyc_n     = 1'b1;
                        adr_n     = beat_adr;
                        wdat_n    = lane_dat;
                        sel_n     = lane_sel;
                        we_n      = we_i;
                        state_n   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (part != 2'd0) begin
                    part_n = beat_part;
                    adr_n  = beat_adr;
                    wdat_n = lane_dat;
                    sel_n  = lane_sel;
                end else begin
                    stb_n   = 1'b0;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
            end
            default: state_n = ST_IDLE;
        endcase

        // Completion overrides the beat sequencing, even mid-ISSUE.
        if (ack_hit) begin
            ack_cnt_n = ack_cnt + 3'd1;
            acc_n     = lane_acc;
            if (ack_cnt + 3'd1 == nb) begin
                state_n   = ST_IDLE;
                ack_cnt_n = 3'd0;
                busy_n    = 1'b0;
                stb_n     = 1'b0;
                cyc_n     = 1'b0;
                rwe_n     = ~l_we;
                if (!l_we) begin
                    dat_n = lane_res;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            part        <= 2'd0;
            nb          <= 3'd0;
            ack_cnt     <= 3'd0;
            acc         <= 64'd0;
            busy_o      <= 1'b0;
            rwe_o       <= 1'b0;
            mis_o       <= 1'b0;
            dat_o       <= 64'd0;
            wb.wbmadr_o <= '0;
            wb.wbmdat_o <= '0;
            wb.wbmsel_o <= '0;
            wb.wbmwe_o  <= 1'b0;
            wb.wbmstb_o <= 1'b0;
            wb.wbmcyc_o <= 1'b0;
        end else begin
            state       <= state_n;
            part        <= part_n;
            nb          <= nb_n;
            ack_cnt     <= ack_cnt_n;
            acc         <= acc_n;
            busy_o      <= busy_n;
            rwe_o       <= rwe_n;
            mis_o       <= mis_n;
            dat_o       <= dat_n;
            wb.wbmadr_o <= adr_n;
            wb.wbmdat_o <= wdat_n;
            wb.wbmsel_o <= sel_n;
            wb.wbmwe_o  <= we_n;
            wb.wbmstb_o <= stb_n;
            wb.wbmcyc_o <= cyc_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            l_addr <= '0;
            l_dat  <= 64'd0;
            l_we   <= 1'b0;
            l_sgn  <= 1'b0;
            l_size <= 2'd0;
        end else if (accept) begin
            l_addr <= addr_i;
            l_dat  <= dat_i;
            l_we   <= we_i;
            l_sgn  <= signed_i;
            l_size <= size_i;
        end
    end

endmodule

// File: tb/tb_lsu_sized.sv
// Randomized bench for lsu_sized at DATA_W=16 against a byte-level access model.
module tb_lsu_sized;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 64;
    localparam int DWB    = DATA_W / 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] addr_i;
    logic [63:0] dat_i;
    logic        we_i, nomem_i, req_i, signed_i;
    logic [1:0]  size_i;
    logic        busy_o, rwe_o, mis_o;
    logic [63:0] dat_o;

    always #5 clk_i = ~clk_i;

    lsu_sized_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    lsu_sized #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .addr_i   (addr_i),
        .dat_i    (dat_i),
        .we_i     (we_i),
        .nomem_i  (nomem_i),
        .req_i    (req_i),
        .size_i   (size_i),
        .signed_i (signed_i),
        .busy_o   (busy_o),
        .rwe_o    (rwe_o),
        .dat_o    (dat_o),
        .mis_o    (mis_o),
        .wb       (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] model_dat = 64'd0;
    logic [15:0] reply_q[$];
    logic [63:0] beat_adr[8];
    logic [15:0] beat_wd[8];
    logic [1:0]  beat_sel[8];
    int          pct_tab[3] = '{100, 60, 25};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] extend(input logic [63:0] v, input int bytes, input logic sgn);
        logic [63:0] m;
        bit sext_en;
        sext_en = 1'b0;
`ifdef LSU_SIGNEXT_EN
        sext_en = 1'b1;
`endif
        if (bytes == 8) return v;
        m = (64'd1 << (8 * bytes)) - 64'd1;
        if (sext_en && sgn && v[8*bytes-1]) return (v & m) | ~m;
        return v & m;
    endfunction

    task automatic do_nomem(input logic [63:0] v);
        @(negedge clk_i);
        nomem_i = 1'b1;
        req_i   = 1'($urandom);
        addr_i  = v;
        size_i  = 2'($urandom);
        @(posedge clk_i);
        @(negedge clk_i);
        nomem_i   = 1'b0;
        req_i     = 1'b0;
        model_dat = v;
        chk("nomem_dat", dat_o, model_dat);
        chk("nomem_rwe", rwe_o, 1);
        chk("nomem_stb", bus.wbmstb_o, 0);
        chk("nomem_busy", busy_o, 0);
        chk("nomem_mis", mis_o, 0);
        @(negedge clk_i);
        chk("nomem_rwe_pulse", rwe_o, 0);
    endtask

    task automatic do_access(input logic [63:0] addr, input logic [63:0] dat, input logic we,
                             input logic [1:0] size, input logic sgn, input int ack_pct);
        int          bytes, nb, off, cycles, pending, beats, m;
        logic [15:0] got_q[$];
        logic [15:0] rd, exp_wd;
        logic [1:0]  exp_sel;
        logic [63:0] v;
        bit          done;
        bytes = 1 << size;
        nb    = (bytes >= DWB) ? bytes / DWB : 1;
        off   = int'(addr % 64'(DWB));
        @(negedge clk_i);
        addr_i = addr; dat_i = dat; we_i = we; size_i = size; signed_i = sgn;
        nomem_i = 1'b0; req_i = 1'b1;
        @(posedge clk_i);
        cycles = 1;
        @(negedge clk_i);
        req_i = 1'b0;
        if ((addr % 64'(bytes)) != 64'd0) begin
            chk("mis_pulse", mis_o, 1);
            chk("mis_stb", bus.wbmstb_o, 0);
            chk("mis_cyc", bus.wbmcyc_o, 0);
            chk("mis_busy", busy_o, 0);
            chk("mis_rwe", rwe_o, 0);
            @(negedge clk_i);
            chk("mis_clear", mis_o, 0);
            chk("mis_stb2", bus.wbmstb_o, 0);
            return;
        end
        chk("req_mis", mis_o, 0);
        pending = 0; beats = 0; done = 0;
        while (cycles < 200) begin
            if (!busy_o) begin
                done = 1;
                break;
            end
            bus.wbmack_i = 1'b0;
            if (bus.wbmstb_o) begin
                chk("beat_in_range", beats < nb, 1);
                if (beats < nb) begin
                    m = nb - 1 - beats;
                    beat_adr[beats] = bus.wbmadr_o;
                    beat_wd[beats]  = bus.wbmdat_o;
                    beat_sel[beats] = bus.wbmsel_o;
                    if (bytes >= DWB) begin
                        exp_wd  = 16'(dat >> (16 * m));
                        exp_sel = 2'b11;
                    end else begin
                        exp_wd  = {dat[7:0], dat[7:0]};
                        exp_sel = 2'(((1 << bytes) - 1) << off);
                    end
                    chk("beat_adr", bus.wbmadr_o, addr + 64'(m * DWB));
                    chk("beat_sel", bus.wbmsel_o, exp_sel);
                    chk("beat_we", bus.wbmwe_o, we);
                    if (we) chk("beat_dat", bus.wbmdat_o, exp_wd);
                end
                beats++;
                pending++;
            end
            chk("busy_cyc", bus.wbmcyc_o, 1);
            if (pending > 0 && $urandom_range(99) < ack_pct) begin
                rd = (reply_q.size() > 0) ? reply_q.pop_front() : 16'($urandom);
                got_q.push_back(rd);
                bus.wbmack_i = 1'b1;
                bus.wbmdat_i = rd;
                pending--;
            end else begin
                bus.wbmdat_i = 16'($urandom);
            end
            @(posedge clk_i);
            cycles++;
            @(negedge clk_i);
        end
        bus.wbmack_i = 1'b0;
        chk("done", done, 1);
        chk("beats", beats, nb);
        if (ack_pct == 100) chk("latency", cycles, nb + 1);
        if (!we) begin
            v = 64'd0;
            foreach (got_q[i]) v = (v << 16) | 64'(got_q[i]);
            if (bytes < DWB) v = v >> (8 * off);
            model_dat = extend(v, bytes, sgn);
        end
        chk("rwe", rwe_o, !we);
        chk("dat_o", dat_o, model_dat);
        chk("end_stb", bus.wbmstb_o, 0);
        chk("end_cyc", bus.wbmcyc_o, 0);
        bus.wbmack_i = 1'b1;
        bus.wbmdat_i = 16'($urandom);
        @(posedge clk_i);
        @(negedge clk_i);
        bus.wbmack_i = 1'b0;
        chk("rwe_pulse", rwe_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_dat", dat_o, model_dat);
    endtask

    task automatic do_reset_mid;
        @(negedge clk_i);
        addr_i = 64'h1122334455667788; dat_i = 64'd0; we_i = 1'b0;
        size_i = 2'b11; signed_i = 1'b0; nomem_i = 1'b0; req_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("wait_busy", busy_o, 1);
        chk("wait_stb", bus.wbmstb_o, 0);
        chk("wait_cyc", bus.wbmcyc_o, 1);
        reset_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_stb", bus.wbmstb_o, 0);
        chk("rst_mid_cyc", bus.wbmcyc_o, 0);
        chk("rst_mid_rwe", rwe_o, 0);
        reset_i   = 1'b0;
        model_dat = 64'd0;
        bus.wbmack_i = 1'b1;
        bus.wbmdat_i = 16'h1234;
        repeat (4) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("post_rst_rwe", rwe_o, 0);
            chk("post_rst_mis", mis_o, 0);
            chk("post_rst_busy", busy_o, 0);
        end
        bus.wbmack_i = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_w, exp_b;
`ifdef LSU_SIGNEXT_EN
        exp_w = 64'hFFFFFFFFDEADBEEF;
        exp_b = 64'hFFFFFFFFFFFFFF80;
`else
        exp_w = 64'h00000000DEADBEEF;
        exp_b = 64'h0000000000000080;
`endif
        reset_i = 1'b1; addr_i = 64'd0; dat_i = 64'd0; we_i = 1'b0; nomem_i = 1'b0;
        req_i = 1'b0; size_i = 2'b00; signed_i = 1'b0;
        bus.wbmack_i = 1'b0; bus.wbmdat_i = 16'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_rwe", rwe_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_mis", mis_o, 0);
        chk("rst_stb", bus.wbmstb_o, 0);
        chk("rst_cyc", bus.wbmcyc_o, 0);
        chk("rst_adr", bus.wbmadr_o, 0);
        chk("rst_sel", bus.wbmsel_o, 0);
        chk("rst_we", bus.wbmwe_o, 0);
        reset_i = 1'b0;

        do_nomem(64'h1122334455667788);

        do_access(64'h1122334455667788, 64'h7766554433221100, 1'b1, 2'b01, 1'b0, 100);
        chk("hs_adr", beat_adr[0], 64'h1122334455667788);
        chk("hs_dat", beat_wd[0], 16'h1100);
        chk("hs_sel", beat_sel[0], 2'b11);

        reply_q.push_back(16'hDEAD);
        reply_q.push_back(16'hBEEF);
        do_access(64'h1122334455667788, 64'h0, 1'b0, 2'b10, 1'b1, 100);
        chk("wl_adr0", beat_adr[0], 64'h112233445566778A);
        chk("wl_adr1", beat_adr[1], 64'h1122334455667788);
        chk("wl_res", dat_o, exp_w);

        reply_q.push_back(16'h80AA);
        do_access(64'h1122334455667789, 64'h0, 1'b0, 2'b00, 1'b1, 100);
        chk("bl_sel", beat_sel[0], 2'b10);
        chk("bl_res", dat_o, exp_b);

        do_access(64'h112233445566778A, 64'h0, 1'b0, 2'b10, 1'b0, 100);

        do_reset_mid();

        for (int t = 0; t < 150; t++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            int          nbytes;
            sz     = 2'($urandom);
            a      = {$urandom, $urandom};
            nbytes = 1 << sz;
            if ($urandom_range(3) != 0) a = a & ~(64'(nbytes) - 64'd1);
            if ($urandom_range(7) == 0) do_nomem(a);
            else do_access(a, {$urandom, $urandom}, 1'($urandom), sz, 1'($urandom),
                           pct_tab[$urandom_range(2)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
